// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - store size encodings, entry layout and lane-alignment helper
package store_pkg;

  localparam int AW = 6;

  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } store_entry_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ok;
  } align_t;

  // ok is set only for a legal size at a naturally aligned offset
  function automatic align_t align_store(input logic [2:0] size, input logic [1:0] off,
                                         input logic [31:0] data);
    align_t     r;
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    r.be    = base << off;
    r.wdata = data << {off, 3'b000};
    r.ok    = (size == SZ_B) || ((size == SZ_H) && !off[0]) || ((size == SZ_W) && (off == 2'b00));
    return r;
  endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - push-side lane/byte-enable generator and misalign detector
module store_align
  import store_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_ok,
  output logic        o_misalign
);

  align_t w_res;
  logic   w_legal;

  assign w_res      = align_store(i_size, i_off, i_data);
  assign w_legal    = (i_size == SZ_B) || (i_size == SZ_H) || (i_size == SZ_W);
  assign o_be       = w_res.be;
  assign o_wdata    = w_res.wdata;
  assign o_ok       = w_res.ok;
  assign o_misalign = w_legal && !w_res.ok;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - DEPTH-entry in-order store FIFO between MEM stage and data memory
module store_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [1:0]             st_off,
  input  logic [2:0]             st_size,
  input  logic [31:0]            st_data,
  output logic                   st_stall,
  output logic                   st_misalign,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hazard,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_misalign;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_ok;
  logic          w_misalign;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;

  store_align u_align (
    .i_size     (st_size),
    .i_off      (st_off),
    .i_data     (st_data),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ok       (w_ok),
    .o_misalign (w_misalign)
  );

  // Full is judged on the registered count alone, so a same-cycle pop never admits a push
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = st_valid && w_ok && !w_full;
  assign w_pop  = mem_valid && mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= st_valid && w_misalign;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {st_addr, w_wdata, w_be};
  end

  // Word-granular match against every occupied slot, head included
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_mem[r_rptr + PW'(i)].addr == ld_addr)) w_hit = 1'b1;
    end
  end

  assign ld_hazard   = ld_valid && w_hit;
  assign st_stall    = w_full;
  assign st_misalign = r_misalign;
  assign empty       = (r_count == '0);
  assign mem_valid   = !empty;
  assign mem_addr    = r_mem[r_rptr].addr;
  assign mem_wdata   = r_mem[r_rptr].wdata;
  assign mem_be      = r_mem[r_rptr].be;
  assign count       = r_count;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed scoreboard bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [5:0]  st_addr;
  logic [1:0]  st_off;
  logic [2:0]  st_size;
  logic [31:0] st_data;
  logic        st_stall;
  logic        st_misalign;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic        ld_hazard;
  logic        mem_valid;
  logic        mem_ready;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;
  logic [2:0]  count;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t sb_q[$];
  ent_t pend_e;
  logic pend;
  int   tests = 0;
  int   fails = 0;

  store_buffer #(.DEPTH(4), .AW(6)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_off(st_off), .st_size(st_size), .st_data(st_data),
    .st_stall(st_stall), .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [5:0] a, input logic [1:0] off, input logic [2:0] sz,
                       input logic [31:0] d, input logic acc, input logic [3:0] eb,
                       input logic [31:0] ed);
    st_valid = 1'b1;
    st_addr  = a;
    st_off   = off;
    st_size  = sz;
    st_data  = d;
    pend     = acc;
    pend_e.a = a;
    pend_e.d = ed;
    pend_e.b = eb;
  endtask

  // Compare a retiring head against the scoreboard, log an accepted push, then clock once
  task automatic step();
    ent_t h;
    #1;
    if (mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        h = sb_q.pop_front();
        chk("pop_addr", 32'(mem_addr), 32'(h.a));
        chk("pop_wdata", mem_wdata, h.d);
        chk("pop_be", 32'(mem_be), 32'(h.b));
      end
    end
    if (pend) sb_q.push_back(pend_e);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    pend     = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    mem_ready = 1'b1;
    while (!empty && guard < 12) begin
      step();
      guard++;
    end
    chk(tag, 32'(empty), 32'd1);
    chk({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_off = '0; st_size = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0; pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stall", 32'(st_stall), 32'd0);
    chk("rst_misalign", 32'(st_misalign), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    store(6'h05, 2'd0, 3'b100, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF);
    step();
    chk("w_valid", 32'(mem_valid), 32'd1);
    chk("w_addr", 32'(mem_addr), 32'h05);
    chk("w_be", 32'(mem_be), 32'hF);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1'b1;
    step();
    chk("w_empty", 32'(empty), 32'd1);
    mem_ready = 1'b0;

    store(6'h01, 2'd3, 3'b001, 32'h000000AB, 1'b1, 4'b1000, 32'hAB000000);
    step();
    chk("b_be", 32'(mem_be), 32'h8);
    chk("b_wdata", mem_wdata, 32'hAB000000);
    mem_ready = 1'b1;
    store(6'h02, 2'd2, 3'b010, 32'h00001234, 1'b1, 4'b1100, 32'h12340000);
    step();
    chk("h_be", 32'(mem_be), 32'hC);
    chk("h_wdata", mem_wdata, 32'h12340000);
    chk("h_count", 32'(count), 32'd1);
    step();
    chk("bh_empty", 32'(empty), 32'd1);
    mem_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      store(6'h20 + 6'(i), 2'd0, 3'b100, 32'h11111111 * (i + 1), 1'b1, 4'hF, 32'h11111111 * (i + 1));
      step();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_stall", 32'(st_stall), 32'd1);
    store(6'h3F, 2'd0, 3'b100, 32'hBADBAD00, 1'b0, 4'hF, 32'hBADBAD00);
    step();
    chk("full_drop_count", 32'(count), 32'd4);
    mem_ready = 1'b1;
    step();
    chk("after_pop_stall", 32'(st_stall), 32'd0);
    chk("after_pop_count", 32'(count), 32'd3);
    drain("fill_drain");

    store(6'h30, 2'd0, 3'b100, 32'hA0000000, 1'b1, 4'hF, 32'hA0000000);
    step();
    store(6'h31, 2'd0, 3'b100, 32'hA0000001, 1'b1, 4'hF, 32'hA0000001);
    step();
    chk("pp_pre_count", 32'(count), 32'd2);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      store(6'h32 + 6'(i), 2'd0, 3'b100, 32'hB0000000 + i, 1'b1, 4'hF, 32'hB0000000 + i);
      step();
      chk("pp_count", 32'(count), 32'd2);
    end
    drain("pp_drain");

    store(6'h07, 2'd2, 3'b100, 32'h55555555, 1'b0, 4'h0, 32'h0);
    step();
    chk("mis_w_pulse", 32'(st_misalign), 32'd1);
    chk("mis_w_count", 32'(count), 32'd0);
    step();
    chk("mis_w_clear", 32'(st_misalign), 32'd0);
    store(6'h07, 2'd1, 3'b010, 32'h00005555, 1'b0, 4'h0, 32'h0);
    step();
    chk("mis_h_pulse", 32'(st_misalign), 32'd1);
    chk("mis_h_count", 32'(count), 32'd0);
    step();
    chk("mis_h_clear", 32'(st_misalign), 32'd0);
    store(6'h07, 2'd0, 3'b011, 32'h12345678, 1'b0, 4'h0, 32'h0);
    step();
    chk("ill_no_pulse", 32'(st_misalign), 32'd0);
    chk("ill_count", 32'(count), 32'd0);

    store(6'h10, 2'd0, 3'b100, 32'hCAFEF00D, 1'b1, 4'hF, 32'hCAFEF00D);
    step();
    ld_valid = 1'b1;
    ld_addr  = 6'h10;
    #1;
    chk("hz_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 6'h11;
    #1;
    chk("hz_miss", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b0;
    store(6'h12, 2'd0, 3'b100, 32'h0BADF00D, 1'b1, 4'hF, 32'h0BADF00D);
    step();
    chk("pre_rst_count", 32'(count), 32'd2);
    mem_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    sb_q.delete();
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    store(6'h3A, 2'd1, 3'b001, 32'h0000005A, 1'b1, 4'b0010, 32'h00005A00);
    step();
    chk("post_rst_addr", 32'(mem_addr), 32'h3A);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
